// File: rtl/fm7_subhalt_pkg.sv
// Shared types and constants for the FM-7 $FD05 sub-CPU halt controller.
package fm7_subhalt_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_REQ    = 2'd1,
    ST_HALTED = 2'd2,
    ST_REL    = 2'd3
  } subhalt_state_t;

  // $FD05 bit positions (write: command bits, read: status bits)
  localparam int FD05_HALT_BIT   = 7;
  localparam int FD05_CANCEL_BIT = 6;
  localparam int FD05_TMO_BIT    = 0;

  // Status bits 5..1 always read back as 1
  localparam logic [7:0] STATUS_ONES = 8'h3E;

endpackage

// File: rtl/fm7_strobe_edge.sv
// CE-qualified falling-edge detector for an active-low register strobe.
// A strobe held low across many CE cycles yields a single event.
module fm7_strobe_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic ce_i,
  input  logic strb_n_i,
  output logic evt_o
);

  logic prev_q;

  // Remember the strobe level seen at the previous CE-qualified sample
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      prev_q <= 1'b1;
    end else if (ce_i) begin
      prev_q <= strb_n_i;
    end
  end

  assign evt_o = ce_i & ~strb_n_i & prev_q;

endmodule

// File: rtl/fm7_subhalt_ctrl.sv
// FM-7 main/sub CPU halt handshake through $FD05 plus shared-RAM grant.
// Optional build macro SUBHALT_TIMEOUT_EN adds a halt-request timeout
// that forces a release and raises STATUS[0].
//
// state  | meaning
// RUN    | sub CPU running, sub owns shared RAM
// REQ    | HALTn asserted, filtering BA/BS for a halt acknowledge
// HALTED | sub halted, main owns shared RAM
// REL    | HALTn released, waiting for sub BA to drop
module fm7_subhalt_ctrl #(
  parameter int ACK_FILT    = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       CE,
  input  logic       WFD05n,
  input  logic       RFD05n,
  input  logic [7:0] DIN,
  input  logic       SUB_BA,
  input  logic       SUB_BS,
  input  logic       SUB_BUSY_SET,
  input  logic       SUB_BUSY_CLR,
  input  logic       SUB_CANCEL_ACK,
  output logic       SUB_HALTn,
  output logic       SHRAM_GNT,
  output logic       CANCEL_IRQ,
  output logic [7:0] STATUS,
  output logic       STAT_RD
);

  import fm7_subhalt_pkg::*;

  localparam logic [2:0] ACK_LAST = 3'(ACK_FILT - 1);

  subhalt_state_t state_q, state_d;
  logic           pend_q, pend_d;
  logic [2:0]     ack_cnt_q, ack_cnt_d;
  logic           busy_q, irq_q, stat_rd_q;
  logic           tmo_q;
  logic           wr_evt, rd_evt;
  logic           halt_req, release_req, sub_ack, ack_done;
  logic [7:0]     status_c;
  logic           unused_din;

  fm7_strobe_edge u_wr_edge (
    .clk_i    (CLK),
    .rst_n_i  (RSTn),
    .ce_i     (CE),
    .strb_n_i (WFD05n),
    .evt_o    (wr_evt)
  );

  fm7_strobe_edge u_rd_edge (
    .clk_i    (CLK),
    .rst_n_i  (RSTn),
    .ce_i     (CE),
    .strb_n_i (RFD05n),
    .evt_o    (rd_evt)
  );

  assign halt_req    = wr_evt &  DIN[FD05_HALT_BIT];
  assign release_req = wr_evt & ~DIN[FD05_HALT_BIT];
  assign sub_ack     = SUB_BA & SUB_BS;
  assign ack_done    = sub_ack & (ack_cnt_q == ACK_LAST);
  assign unused_din  = ^DIN[5:0];

`ifdef SUBHALT_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 8192) ? $clog2(TIMEOUT_CYC) : 13;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_d;
  logic          tmo_expire;

  assign tmo_expire = (tmo_cnt_q == '0);

  // Down-counter reloaded outside REQ, so every REQ entry starts a full window
  always_ff @(posedge CLK) begin
    if (!RSTn || state_q != ST_REQ) begin
      tmo_cnt_q <= TMO_LOAD;
    end else if (!tmo_expire) begin
      tmo_cnt_q <= tmo_cnt_q - 1'b1;
    end
  end

  // Timeout flag register
  always_ff @(posedge CLK) begin
    if (!RSTn) tmo_q <= 1'b0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_q = 1'b0;
`endif

  // State and handshake registers
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= ST_RUN;
      pend_q    <= 1'b0;
      ack_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

  // Next-state logic; ack counter is zero whenever not counting in REQ
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    ack_cnt_d = '0;
`ifdef SUBHALT_TIMEOUT_EN
    tmo_d     = halt_req ? 1'b0 : tmo_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (release_req) begin
          pend_d = 1'b0;
        end else if (halt_req || pend_q) begin
          state_d = ST_REQ;
          pend_d  = 1'b0;
        end
      end
      ST_REQ: begin
        if (release_req) begin
          state_d = ST_REL;
        end else if (ack_done) begin
          state_d = ST_HALTED;
        end else begin
          if (sub_ack) ack_cnt_d = ack_cnt_q + 3'd1;
`ifdef SUBHALT_TIMEOUT_EN
          if (tmo_expire) begin
            state_d = ST_REL;
            tmo_d   = 1'b1;
          end
`endif
        end
      end
      ST_HALTED: begin
        if (release_req) state_d = ST_REL;
      end
      ST_REL: begin
        if (halt_req) pend_d = 1'b1;
        if (!SUB_BA)  state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Busy flag, cancel interrupt and read pulse; set beats clear in both flags
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      busy_q    <= 1'b1;
      irq_q     <= 1'b0;
      stat_rd_q <= 1'b0;
    end else begin
      if (SUB_BUSY_SET)      busy_q <= 1'b1;
      else if (SUB_BUSY_CLR) busy_q <= 1'b0;
      if (wr_evt && DIN[FD05_CANCEL_BIT]) irq_q <= 1'b1;
      else if (SUB_CANCEL_ACK)            irq_q <= 1'b0;
      stat_rd_q <= rd_evt;
    end
  end

  // $FD05 read value
  always_comb begin
    status_c                  = STATUS_ONES;
    status_c[FD05_HALT_BIT]   = busy_q | (state_q != ST_RUN);
    status_c[FD05_CANCEL_BIT] = irq_q;
    status_c[FD05_TMO_BIT]    = tmo_q;
  end

  assign SUB_HALTn  = ~((state_q == ST_REQ) | (state_q == ST_HALTED));
  assign SHRAM_GNT  = (state_q == ST_HALTED);
  assign CANCEL_IRQ = irq_q;
  assign STATUS     = status_c;
  assign STAT_RD    = stat_rd_q;

endmodule
